// File: rtl/step_run_controller.sv
// Single-step / auto-repeat / free-run clock-enable generator for the processor,
// driven by a debounced push-button level and a run-mode slide switch.
module step_run_controller #(
  parameter int HOLD_DELAY    = 13500000,
  parameter int REPEAT_PERIOD = 2700000,
  parameter int RUN_PERIOD    = 270000,
  parameter int CNT_W         = 16
) (
  input  logic             clock27MHz,
  input  logic             resetn,
  input  logic             pb_level,
  input  logic             run_mode,
  input  logic             halt,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state
);

  localparam int MAX_HR = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int MAX_P  = (MAX_HR > RUN_PERIOD) ? MAX_HR : RUN_PERIOD;
  localparam int TW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] HOLD_END   = TW'(HOLD_DELAY - 1);
  localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] RUN_END    = TW'(RUN_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer;
  logic            pb_prev;
  logic            rm_meta;
  logic            rm_s;
  logic            pb_rise;

  assign pb_rise = pb_level & ~pb_prev;
  assign state   = state_reg;

  // Every step decision raises step_pulse for the following cycle and bumps
  // the count at the same edge, so the two always stay in lockstep.
  always_ff @(posedge clock27MHz or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      timer      <= '0;
      pb_prev    <= 1'b0;
      rm_meta    <= 1'b0;
      rm_s       <= 1'b0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      rm_meta    <= run_mode;
      rm_s       <= rm_meta;
      pb_prev    <= pb_level;
      step_pulse <= 1'b0;

      if (halt) begin
        state_reg <= IDLE;
        timer     <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            timer <= '0;
            if (rm_s) begin
              state_reg <= RUN;
            end else if (pb_rise) begin
              state_reg  <= PRESSED;
              step_pulse <= 1'b1;
              step_count <= step_count + CNT_W'(1);
            end
          end

          PRESSED: begin
            if (!pb_level) begin
              state_reg <= IDLE;
              timer     <= '0;
            end else if (rm_s) begin
              state_reg <= RUN;
              timer     <= '0;
            end else if (timer == HOLD_END) begin
              state_reg  <= REPEAT;
              timer      <= '0;
              step_pulse <= 1'b1;
              step_count <= step_count + CNT_W'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end

          REPEAT: begin
            // Release wins over a timer expiring on the same edge.
            if (!pb_level) begin
              state_reg <= IDLE;
              timer     <= '0;
            end else if (rm_s) begin
              state_reg <= RUN;
              timer     <= '0;
            end else if (timer == REPEAT_END) begin
              timer      <= '0;
              step_pulse <= 1'b1;
              step_count <= step_count + CNT_W'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end

          RUN: begin
            // Leaving RUN lands in IDLE; a button still held needs a fresh press.
            if (!rm_s) begin
              state_reg <= IDLE;
              timer     <= '0;
            end else if (timer == RUN_END) begin
              timer      <= '0;
              step_pulse <= 1'b1;
              step_count <= step_count + CNT_W'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end

          default: begin
            state_reg <= IDLE;
            timer     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_run_controller.sv
// Bench for step_run_controller: directed scenarios followed by random button,
// switch and halt activity, all checked against a countdown-based reference model.
`timescale 1ns/1ps
module tb_step_run_controller;

  localparam int HOLD   = 8;
  localparam int REP    = 4;
  localparam int RUNP   = 5;
  localparam int CNT_W  = 4;

  localparam int S_IDLE = 0, S_PRESSED = 1, S_REPEAT = 2, S_RUN = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             pb = 1'b0;
  logic             rm = 1'b0;
  logic             halt = 1'b0;
  logic             step_pulse;
  logic [CNT_W-1:0] step_count;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;
  int n_pulses = 0;
  logic last_pulse = 1'b0;

  // Reference model: a mode, a countdown of cycles until the next pulse, a
  // two-deep run_mode history and the previous button level.
  int   m_mode;
  int   m_remaining;
  int   m_count;
  bit   m_pulse;
  bit   m_pb_prev;
  bit   m_rm_hist [2];

  step_run_controller #(
    .HOLD_DELAY   (HOLD),
    .REPEAT_PERIOD(REP),
    .RUN_PERIOD   (RUNP),
    .CNT_W        (CNT_W)
  ) dut (
    .clock27MHz(clk),
    .resetn    (resetn),
    .pb_level  (pb),
    .run_mode  (rm),
    .halt      (halt),
    .step_pulse(step_pulse),
    .step_count(step_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode       = S_IDLE;
    m_remaining  = 0;
    m_count      = 0;
    m_pulse      = 1'b0;
    m_pb_prev    = 1'b0;
    m_rm_hist[0] = 1'b0;
    m_rm_hist[1] = 1'b0;
  endtask

  task automatic model_edge();
    bit pressed_now;
    bit run_on;
    if (!resetn) begin
      model_reset();
      return;
    end
    pressed_now = pb && !m_pb_prev;
    run_on      = m_rm_hist[1];
    m_pulse     = 1'b0;
    if (halt) begin
      m_mode = S_IDLE;
    end else if (m_mode == S_IDLE) begin
      if (run_on) begin
        m_mode = S_RUN; m_remaining = RUNP;
      end else if (pressed_now) begin
        m_pulse = 1'b1; m_mode = S_PRESSED; m_remaining = HOLD;
      end
    end else if (m_mode == S_RUN) begin
      if (!run_on) m_mode = S_IDLE;
      else begin
        m_remaining--;
        if (m_remaining == 0) begin m_pulse = 1'b1; m_remaining = RUNP; end
      end
    end else begin
      if (!pb) m_mode = S_IDLE;
      else if (run_on) begin m_mode = S_RUN; m_remaining = RUNP; end
      else begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_pulse = 1'b1; m_mode = S_REPEAT; m_remaining = REP;
        end
      end
    end
    if (m_pulse) m_count = (m_count + 1) % (1 << CNT_W);
    m_pb_prev    = pb;
    m_rm_hist[1] = m_rm_hist[0];
    m_rm_hist[0] = rm;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (step_pulse === m_pulse) else begin
      errors++;
      $error("FAIL %s pulse t=%0t got %b exp %b", tag, $time, step_pulse, m_pulse);
    end
    checks++;
    assert (step_count === CNT_W'(m_count)) else begin
      errors++;
      $error("FAIL %s count t=%0t got %0d exp %0d", tag, $time, step_count, m_count);
    end
    checks++;
    assert (state === 2'(m_mode)) else begin
      errors++;
      $error("FAIL %s state t=%0t got %0d exp %0d", tag, $time, state, m_mode);
    end
    checks++;
    assert (!(step_pulse && last_pulse)) else begin
      errors++;
      $error("FAIL %s back_to_back t=%0t got 11 exp not 11", tag, $time);
    end
    last_pulse = step_pulse;
    if (step_pulse === 1'b1) n_pulses++;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    tick("reset");
    tick("reset");
    resetn = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    @(negedge clk);
    check_outputs("reset_state");
    do_reset();
    repeat (3) tick("idle");

    // Short press: one pulse, back to IDLE.
    n_pulses = 0;
    pb = 1'b1; repeat (2) tick("short");
    pb = 1'b0; repeat (3) tick("short");
    expect_int("short_pulses", n_pulses, 1);
    expect_int("short_count", int'(step_count), 1);
    expect_int("short_state", int'(state), S_IDLE);

    // Held press: 30 edges held gives pulses at 0,8,12,...,28.
    n_pulses = 0;
    pb = 1'b1; repeat (30) tick("held");
    pb = 1'b0; repeat (10) tick("held_rel");
    expect_int("held_pulses", n_pulses, 7);
    expect_int("held_count", int'(step_count), 8);

    // Run mode: 16 pulses wrap the 4-bit count back to zero.
    do_reset();
    n_pulses = 0;
    rm = 1'b1; repeat (83) tick("run");
    expect_int("run_pulses", n_pulses, 16);
    expect_int("run_wrap_count", int'(step_count), 0);
    rm = 1'b0; repeat (3) tick("run_off");
    expect_int("run_off_state", int'(state), S_IDLE);
    n_pulses = 0;
    repeat (10) tick("run_off");
    expect_int("run_off_pulses", n_pulses, 0);

    // Halt during REPEAT, then held button must not step.
    do_reset();
    pb = 1'b1; repeat (10) tick("halt_pre");
    expect_int("halt_pre_state", int'(state), S_REPEAT);
    n_pulses = 0;
    halt = 1'b1; repeat (6) tick("halt");
    expect_int("halt_pulses", n_pulses, 0);
    expect_int("halt_state", int'(state), S_IDLE);
    halt = 1'b0; repeat (10) tick("halt_held");
    expect_int("halt_held_pulses", n_pulses, 0);
    pb = 1'b0; repeat (2) tick("halt_rel");
    pb = 1'b1; repeat (3) tick("halt_repress");
    pb = 1'b0; repeat (2) tick("halt_repress");
    expect_int("halt_repress_pulses", n_pulses, 1);

    // Run switch while PRESSED: no hold pulse, first run pulse RUNP after entry.
    do_reset();
    pb = 1'b1; repeat (2) tick("mode_sw");
    n_pulses = 0;
    rm = 1'b1; repeat (7) tick("mode_sw");
    expect_int("mode_sw_no_hold", n_pulses, 0);
    tick("mode_sw");
    expect_int("mode_sw_run_pulse", n_pulses, 1);
    rm = 1'b0; pb = 1'b0; repeat (4) tick("mode_sw_off");

    // Asynchronous reset mid-cycle during REPEAT with count 5.
    do_reset();
    pb = 1'b1; repeat (21) tick("areset_pre");
    expect_int("areset_pre_count", int'(step_count), 5);
    expect_int("areset_pre_state", int'(state), S_REPEAT);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("areset_now");
    repeat (2) tick("areset_hold");
    resetn = 1'b1;
    repeat (12) tick("areset_after");
    pb = 1'b0; repeat (3) tick("areset_after");

    // Random activity.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        halt = 1'b1;
        repeat ($urandom_range(1, 4)) tick("rnd_halt");
        halt = 1'b0;
      end else if (r <= 2) begin
        rm = ~rm;
        repeat ($urandom_range(1, 30)) tick("rnd_rm");
      end else begin
        pb = 1'b1;
        for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
          halt = ($urandom_range(0, 19) == 0);
          tick("rnd_pb");
        end
        halt = 1'b0;
        pb = 1'b0;
        repeat ($urandom_range(1, 6)) tick("rnd_rel");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
